// File: rtl/vga_pkg.sv
// Shared VGA timing constants, receiver FSM states and small helpers.
// Used by both the receiver and the transmitter side of the video path.
package vga_pkg;

  // Horizontal timing in pixels, measured from the hsync falling edge.
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_VIS   = 640;
  localparam int H_TOTAL = 800;

  // Vertical timing in lines, measured from the vsync falling edge.
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_VIS   = 480;
  localparam int V_TOTAL = 525;

  // Position counters are 10 bits wide and stick at all-ones once sync is lost.
  localparam int         CNT_W   = 10;
  localparam logic [9:0] CNT_MAX = 10'd1023;

  // Colour is one bit per channel, packed as {R,G,B}.
  localparam int RGB_W = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } vga_state_e;

  // True when pos lies in the half-open window [start, start+len).
  function automatic logic inWindow(input logic [9:0] pos, input int start, input int len);
    int p;
    p = int'(pos);
    return (p >= start) && (p < start + len);
  endfunction

endpackage

// File: rtl/vga_rx_sync.sv
// Input pipeline for the VGA receiver: two equal-depth stages for sync and
// colour so they stay aligned, plus falling-edge detection on stage-2 syncs.
module vga_rx_sync
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pixEn_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic [RGB_W-1:0] rgb_i,
  output logic             hsFall_o,
  output logic             vsFall_o,
  output logic [RGB_W-1:0] rgb_o
);

  logic hs1_q, hs2_q, hsPrev_q;
  logic vs1_q, vs2_q, vsPrev_q;
  logic [RGB_W-1:0] rgb1_q, rgb2_q;

  // Sync pipeline; idle level is high, and a third register keeps the last
  // stage-2 value so a falling edge can be seen on the current stage-2 sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs1_q    <= 1'b1;
      hs2_q    <= 1'b1;
      hsPrev_q <= 1'b1;
      vs1_q    <= 1'b1;
      vs2_q    <= 1'b1;
      vsPrev_q <= 1'b1;
    end else if (pixEn_i) begin
      hs1_q    <= hsync_i;
      hs2_q    <= hs1_q;
      hsPrev_q <= hs2_q;
      vs1_q    <= vsync_i;
      vs2_q    <= vs1_q;
      vsPrev_q <= vs2_q;
    end
  end

  // Colour pipeline, same depth as the sync path so stage-2 colour belongs
  // to the same pixel as stage-2 sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb1_q <= '0;
      rgb2_q <= '0;
    end else if (pixEn_i) begin
      rgb1_q <= rgb_i;
      rgb2_q <= rgb1_q;
    end
  end

  assign hsFall_o = hsPrev_q & ~hs2_q;
  assign vsFall_o = vsPrev_q & ~vs2_q;
  assign rgb_o    = rgb2_q;

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: recovers pixel coordinates from active-low hsync/vsync,
// verifies line and frame length before declaring lock, and presents the
// visible pixels with their coordinates. Timing defaults to 640x480@800x525
// and can be overridden for other modes.
module vga_rx
  import vga_pkg::*;
#(
  parameter int H_TOTAL_P = H_TOTAL,
  parameter int H_START_P = H_START,
  parameter int H_VIS_P   = H_VIS,
  parameter int V_TOTAL_P = V_TOTAL,
  parameter int V_START_P = V_START,
  parameter int V_VIS_P   = V_VIS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       R,
  input  logic       G,
  input  logic       B,
  output logic [9:0] CounterX,
  output logic [8:0] CounterY,
  output logic       ins,
  output logic [2:0] pix_rgb,
  output logic       frame_start,
  output logic       locked,
  output logic       err
);

  logic             hsFall, vsFall;
  logic [RGB_W-1:0] rgbS2;

  logic [CNT_W-1:0] hCnt_q, hCnt_d;
  logic [CNT_W-1:0] vCnt_q, vCnt_d;
  vga_state_e       state_q;

  logic       lineBad, frameBad, hSat, vSat;
  logic       violation, lockedNext;
  logic       visible, showPix;
  logic [9:0] xPos;
  logic [8:0] yPos;

  vga_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .pixEn_i  (pix_en),
    .hsync_i  (hsync),
    .vsync_i  (vsync),
    .rgb_i    ({R, G, B}),
    .hsFall_o (hsFall),
    .vsFall_o (vsFall),
    .rgb_o    (rgbS2)
  );

  // Position of the current stage-2 pixel. An hsync edge restarts the line;
  // a vsync edge is applied after the line increment so a coincident pair
  // lands on row 0. Both counters stick at all-ones when edges stop coming.
  always_comb begin
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (hsFall) begin
      hCnt_d = '0;
    end else if (hCnt_q != CNT_MAX) begin
      hCnt_d = hCnt_q + 10'd1;
    end
    if (hsFall && (vCnt_q != CNT_MAX)) begin
      vCnt_d = vCnt_q + 10'd1;
    end
    if (vsFall) begin
      vCnt_d = '0;
    end
  end

  // Timing checks against the previous pixel/line position, plus the lock
  // decision that the output stage uses on this same strobe.
  always_comb begin
    lineBad    = hsFall && (hCnt_q != 10'(H_TOTAL_P - 1));
    frameBad   = vsFall && (vCnt_q != 10'(V_TOTAL_P - 1));
    hSat       = (hCnt_d == CNT_MAX);
    vSat       = (vCnt_d == CNT_MAX);
    violation  = (state_q != HUNT) && (lineBad || frameBad || hSat || vSat);
    lockedNext = !violation &&
                 ((state_q == LOCKED) || ((state_q == CHECK) && vsFall));
  end

  // Visible-window test and coordinates relative to the first visible pixel.
  always_comb begin
    visible = inWindow(hCnt_d, H_START_P, H_VIS_P) &&
              inWindow(vCnt_d, V_START_P, V_VIS_P);
    showPix = visible && lockedNext;
    xPos    = hCnt_d - 10'(H_START_P);
    yPos    = vCnt_d[8:0] - 9'(V_START_P);
  end

  // Position counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else if (pix_en) begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  // Lock FSM with its registered outputs; any violation sends it back to
  // HUNT and drops locked on the same strobe that raises err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      locked      <= 1'b0;
      err         <= 1'b0;
      ins         <= 1'b0;
      CounterX    <= '0;
      CounterY    <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      case (state_q)
        HUNT: begin
          if (vsFall) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (violation) begin
            state_q <= HUNT;
          end else if (vsFall) begin
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (violation) begin
            state_q <= HUNT;
          end
        end
        default: state_q <= HUNT;
      endcase
      locked      <= lockedNext;
      err         <= violation;
      ins         <= showPix;
      CounterX    <= showPix ? xPos : 10'd0;
      CounterY    <= showPix ? yPos : 9'd0;
      pix_rgb     <= showPix ? rgbS2 : 3'd0;
      frame_start <= showPix && (xPos == 10'd0) && (yPos == 9'd0);
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// Testbench for vga_rx: drives short-format frames from a small transmitter
// model, queues the expected visible pixels, and a monitor checks each output.
module tb_vga_rx;

  localparam int TH_TOTAL = 40;
  localparam int TH_SYNC  = 8;
  localparam int TH_START = 12;
  localparam int TH_VIS   = 24;
  localparam int TV_TOTAL = 20;
  localparam int TV_SYNC  = 2;
  localparam int TV_START = 4;
  localparam int TV_VIS   = 12;

  logic       clk = 1'b0;
  logic       rst, pix_en, hsync, vsync, R, G, B;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic       ins, frame_start, locked, err;
  logic [2:0] pix_rgb;

  typedef struct {
    int x;
    int y;
    int rgb;
    int strobe;
  } exp_t;

  exp_t expQ[$];
  exp_t e;

  int   checks = 0;
  int   errors = 0;
  int   strobeCnt = 0;
  int   errCnt = 0;
  int   insCnt = 0;
  int   frameStartCnt = 0;
  int   expFrameStarts = 0;
  int   lockRiseStrobe = -1;
  int   frameStartStrobe = 0;
  bit   gateHalf = 1'b0;
  logic lockedPrev = 1'b0;

  vga_rx #(
    .H_TOTAL_P (TH_TOTAL),
    .H_START_P (TH_START),
    .H_VIS_P   (TH_VIS),
    .V_TOTAL_P (TV_TOTAL),
    .V_START_P (TV_START),
    .V_VIS_P   (TV_VIS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .R           (R),
    .G           (G),
    .B           (B),
    .CounterX    (CounterX),
    .CounterY    (CounterY),
    .ins         (ins),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .locked      (locked),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Hand-picked colour pattern; the bottom-right visible pixel is 3'b101.
  function automatic int pixColour(input int x, input int y);
    if (x == TH_VIS - 1 && y == TV_VIS - 1) return 5;
    return (x + 3 * y + 1) % 8;
  endfunction

  // Drive one pixel at line position (hx, vy); queue it if it is visible
  // and the receiver is expected to be locked for it.
  task automatic applyStimulus(input int hx, input int vy, input bit push);
    logic [2:0] c;
    bit         vis;
    vis = (hx >= TH_START) && (hx < TH_START + TH_VIS) &&
          (vy >= TV_START) && (vy < TV_START + TV_VIS);
    c = vis ? 3'(pixColour(hx - TH_START, vy - TV_START)) : 3'b111;
    if (gateHalf) begin
      @(negedge clk);
      pix_en = 1'b0;
      {hsync, vsync, R, G, B} = 5'($urandom);
    end
    @(negedge clk);
    pix_en = 1'b1;
    hsync  = (hx >= TH_SYNC);
    vsync  = (vy >= TV_SYNC);
    {R, G, B} = c;
    if (hx == 0 && vy == 0) frameStartStrobe = strobeCnt + 1;
    if (push && vis) begin
      expQ.push_back('{x: hx - TH_START, y: vy - TV_START, rgb: int'(c), strobe: strobeCnt + 3});
      if (hx == TH_START && vy == TV_START) expFrameStarts++;
    end
  endtask

  task automatic pause();
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic sendLine(input int vy, input int len, input bit push);
    for (int hx = 0; hx < len; hx++) applyStimulus(hx, vy, push);
  endtask

  // A frame of nLines lines; line shortLine is one pixel short, and only
  // lines below pushLines are expected on the output.
  task automatic sendFrame(input int nLines, input int shortLine, input int pushLines);
    for (int vy = 0; vy < nLines; vy++)
      sendLine(vy, (vy == shortLine) ? TH_TOTAL - 1 : TH_TOTAL, vy < pushLines);
    pause();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " CounterX"}, int'(CounterX), 0);
    checkOutput({tag, " CounterY"}, int'(CounterY), 0);
    checkOutput({tag, " ins"}, int'(ins), 0);
    checkOutput({tag, " pix_rgb"}, int'(pix_rgb), 0);
    checkOutput({tag, " frame_start"}, int'(frame_start), 0);
    checkOutput({tag, " locked"}, int'(locked), 0);
    checkOutput({tag, " err"}, int'(err), 0);
  endtask

  // Monitor: on every pixel strobe, compare the visible output against the
  // queue head and require all-zero outputs outside the visible area.
  always @(posedge clk) begin
    if (!rst && pix_en) begin
      strobeCnt++;
      #1;
      if (err) errCnt++;
      if (frame_start) frameStartCnt++;
      if (locked && !lockedPrev) lockRiseStrobe = strobeCnt;
      lockedPrev = locked;
      if (ins) begin
        insCnt++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected ins", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("CounterX", int'(CounterX), e.x);
          checkOutput("CounterY", int'(CounterY), e.y);
          checkOutput("pix_rgb", int'(pix_rgb), e.rgb);
          checkOutput("latency strobe", strobeCnt, e.strobe);
          checkOutput("frame_start", int'(frame_start), (e.x == 0 && e.y == 0) ? 1 : 0);
        end
      end else begin
        checkOutput("blank outputs", int'({CounterX, CounterY, pix_rgb, frame_start}), 0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    pix_en = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    {R, G, B} = 3'b000;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Two clean frames lock the receiver at the second vsync edge.
    sendFrame(TV_TOTAL, -1, 0);
    checkOutput("locked after first frame", int'(locked), 0);
    sendFrame(TV_TOTAL, -1, TV_TOTAL);
    checkOutput("locked after second frame", int'(locked), 1);
    checkOutput("lock strobe", lockRiseStrobe, frameStartStrobe + 2);
    sendFrame(TV_TOTAL, -1, TV_TOTAL);
    checkOutput("frame_start count", frameStartCnt, 2);
    checkOutput("ins count", insCnt, 2 * TH_VIS * TV_VIS);
    checkOutput("err clean frames", errCnt, 0);
    checkOutput("queue drained", expQ.size(), 0);

    // Short line while locked, then relock over two clean frames.
    sendFrame(TV_TOTAL, 6, 7);
    checkOutput("err short line", errCnt, 1);
    checkOutput("locked short line", int'(locked), 0);
    sendFrame(TV_TOTAL, -1, 0);
    checkOutput("locked relock check", int'(locked), 0);
    sendFrame(TV_TOTAL, -1, TV_TOTAL);
    checkOutput("locked relocked", int'(locked), 1);
    checkOutput("err after relock", errCnt, 1);

    // Frame one line short: error at the following vsync edge, back to HUNT.
    sendFrame(TV_TOTAL - 1, -1, TV_TOTAL);
    checkOutput("err before vsync", errCnt, 1);
    checkOutput("locked short frame", int'(locked), 1);
    sendFrame(TV_TOTAL, -1, 0);
    checkOutput("err short frame", errCnt, 2);
    checkOutput("locked after short frame", int'(locked), 0);
    sendFrame(TV_TOTAL, -1, 0);
    checkOutput("locked hunt restart", int'(locked), 0);
    sendFrame(TV_TOTAL, -1, TV_TOTAL);
    checkOutput("locked after hunt", int'(locked), 1);

    // hsync stuck high long enough to saturate the line counter.
    for (int i = 0; i < 1100; i++) applyStimulus(TH_TOTAL, TV_SYNC, 1'b0);
    pause();
    checkOutput("err saturation", errCnt, 3);
    checkOutput("locked saturation", int'(locked), 0);

    // Same traffic with pix_en at half rate.
    gateHalf = 1'b1;
    sendFrame(TV_TOTAL, -1, 0);
    checkOutput("locked gated first", int'(locked), 0);
    sendFrame(TV_TOTAL, -1, TV_TOTAL);
    checkOutput("locked gated second", int'(locked), 1);
    checkOutput("err gated", errCnt, 3);

    // Reset in the middle of a visible line.
    for (int vy = 0; vy < 7; vy++) sendLine(vy, TH_TOTAL, 1'b1);
    sendLine(7, 20, 1'b1);
    pause();
    checkOutput("ins before reset", int'(ins), 1);
    checkOutput("locked before reset", int'(locked), 1);
    #2 rst = 1'b1;
    #1;
    checkAllZero("async reset");
    expQ.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lockedPrev = 1'b0;
    sendFrame(TV_TOTAL, -1, 0);
    checkOutput("locked after reset frame", int'(locked), 0);
    sendFrame(TV_TOTAL, -1, TV_TOTAL);
    checkOutput("locked after reset relock", int'(locked), 1);

    checkOutput("final queue drained", expQ.size(), 0);
    checkOutput("final frame_start count", frameStartCnt, expFrameStarts);
    checkOutput("final err count", errCnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 SHALL have a single clock, `clk`: input, 1 bit, rising-edge system clock.
REQ-002 SHALL have reset `rst`: input, 1 bit, asynchronous, active-high.
REQ-003 SHALL have `pix_en`: input, 1 bit, pixel strobe; all logic advances only on clk edges with pix_en=1.
REQ-004 SHALL have `hsync` and `vsync`: inputs, 1 bit each, active-low sync from the video source.
REQ-005 SHALL have `R`, `G`, `B`: inputs, 1 bit each, pixel colour.
REQ-006 SHALL have `CounterX`: output, 10 bits, recovered visible column 0..639.
REQ-007 SHALL have `CounterY`: output, 9 bits, recovered visible row 0..479.
REQ-008 SHALL have `ins`: output, 1 bit, high when the current output pixel is inside the visible area and the receiver is locked.
REQ-009 SHALL have `pix_rgb`: output, 3 bits, {R,G,B} aligned with CounterX/CounterY.
REQ-010 SHALL have `frame_start`: output, 1 bit, one-pix_en pulse with pixel (0,0).
REQ-011 SHALL have `locked`: output, 1 bit, timing verified.
REQ-012 SHALL have `err`: output, 1 bit, one-pix_en pulse on a timing violation.

Function
REQ-013 SHALL register hsync, vsync and RGB through two pix_en-qualified stages of equal depth, so sync and colour stay aligned.
REQ-014 SHALL detect falling edges of the stage-2 hsync and vsync.
REQ-015 SHALL run h counter (10 bit): cleared to 0 on an hsync falling edge, otherwise +1 per pix_en, saturating at 1023.
REQ-016 SHALL run v counter (10 bit): cleared to 0 on a vsync falling edge, otherwise +1 on each hsync falling edge, saturating at 1023.
REQ-017 SHALL evaluate a vsync falling edge after the hsync edge on the same pix_en when both occur together.
REQ-018 SHALL use timing constants: H_TOTAL=800, H_START=144 (sync 96 + back porch 48), H_VIS=640; V_TOTAL=525, V_START=35 (sync 2 + back porch 33), V_VIS=480.
REQ-019 SHALL use FSM states HUNT, CHECK, LOCKED.
REQ-020 SHALL transition HUNT -> CHECK on the first vsync falling edge.
REQ-021 SHALL, in CHECK, verify that each hsync falling edge arrives with h==H_TOTAL-1.
REQ-022 SHALL, in CHECK, verify that the next vsync falling edge arrives with v==V_TOTAL-1; if so, CHECK -> LOCKED.
REQ-023 SHALL, in CHECK or LOCKED, treat a line-length or frame-length mismatch as a violation: pulse err, go to HUNT, drop locked the same cycle.
REQ-024 SHALL treat saturation of either counter (sync lost) as a violation, with the same response as REQ-023.
REQ-025 SHALL drive locked=1 only in LOCKED.
REQ-026 SHALL compute visible area as H_START<=h<H_START+H_VIS and V_START<=v<V_START+V_VIS.
REQ-027 SHALL, when visible and LOCKED: CounterX=h-H_START, CounterY=v-V_START, ins=1, pix_rgb=stage-2 RGB; otherwise CounterX=0, CounterY=0, ins=0, pix_rgb=0.
REQ-028 SHALL register all outputs, updating only on pix_en.
REQ-029 SHALL have a latency of 3 pix_en strobes from an input sample to its pix_rgb.
REQ-030 SHALL pulse frame_start when the output pixel is (0,0) with ins=1, and SHALL hold it low otherwise.
REQ-031 SHALL hold all state and outputs unchanged while pix_en=0.

Reset
REQ-032 SHALL, on rst, clear: FSM=HUNT, counters=0, sync stages=1 (idle), RGB stages=0, all outputs 0.
REQ-033 SHALL, when rst asserts mid-frame, drop locked and ins immediately and resume hunting on release.

Structure
REQ-034 SHALL place timing constants and the FSM state enum in shared package vga_pkg, reused by the transmitter.
REQ-035 SHALL implement edge detection and the sync/RGB input pipeline as sub-module vga_rx_sync.

Verification
REQ-036 SHALL cover: two clean 800x525 frames from the transmitter -> locked=1 at the second vsync edge; frame_start once per frame; ins high for 640x480 pixels per frame.
REQ-037 SHALL cover: pixel (639,479) driven as RGB=101 -> pix_rgb=101 with CounterX=639, CounterY=479, 3 strobes after input.
REQ-038 SHALL cover: one line of 799 pixels while locked -> err pulse, locked=0, then relock after two clean frames.
REQ-039 SHALL cover: a frame of 524 lines -> err at the vsync edge, FSM returns to HUNT.
REQ-040 SHALL cover: hsync held high for 1100 pixels -> err on saturation, locked=0.
REQ-041 SHALL cover: rst asserted mid-visible line -> all outputs 0 asynchronously; pix_en gated to 50% produces identical output sequences.
